psum_accum_buffer: RTL and testbench

- Partial-sum storage stage directly downstream of the 16-lane MAC array. It closes the accumulation loop.
- Each cycle it captures 16 lanes × 24-bit partial sums into one of 16 entries, and feeds the same entry back to the MAC array as its next partial_sum_in.
- After a programmed number of passes, it drains the finished 16×16 tile row by row over a valid/ready interface to the writeback stage.

---
 rtl/mac_pkg.sv | 19 +
 rtl/psum_accum_buffer_if.sv | 31 +++
 rtl/psum_sat.sv | 28 ++
 rtl/psum_accum_buffer.sv | 140 ++++++++++++++
 tb/tb_psum_accum_buffer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared MAC-array constants and the accumulate-buffer state encoding.
//   LANES  : MAC lanes per entry
//   DEPTH  : entries per pass (power of two)
//   PSUM_W : signed partial-sum width per lane
//   IDX_W  : entry / row index width
package mac_pkg;

  localparam int unsigned LANES  = 16;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned PSUM_W = 24;
  localparam int unsigned IDX_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } state_e;

endpackage

// File: rtl/psum_accum_buffer_if.sv
// Drain-side valid/ready bus from the partial-sum buffer to writeback.
//   out_valid : row available        (master -> slave)
//   out_ready : row accepted         (slave  -> master)
//   out_data  : LANES x OUT_W row, lane i at [i*OUT_W +: OUT_W]
//   out_idx   : row index of out_data
interface psum_accum_buffer_if
  import mac_pkg::*;
#(
  parameter int unsigned OUT_W = PSUM_W
);

  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_data;
  logic [IDX_W-1:0]       out_idx;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/psum_sat.sv
// Single-lane signed clamp from IN_W to OUT_W bits (two's complement).
//   din  : signed input value
//   dout : din, or the nearest OUT_W-bit extreme when din is out of range
module psum_sat #(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned OUT_W = 24
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  if (OUT_W == IN_W) begin : g_pass
    assign dout = din;
  end else begin : g_clamp
    logic in_range;

    // Representable iff every bit above the OUT_W sign bit equals the sign.
    assign in_range = (din[IN_W-1:OUT_W-1] == {(IN_W - OUT_W + 1){din[IN_W-1]}});

    always_comb begin
      dout = din[OUT_W-1:0];
      if (!in_range) begin
        dout = din[IN_W-1] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/psum_accum_buffer.sv
// Partial-sum accumulation buffer closing the MAC-array loop.
// Captures one LANES x PSUM_W result per valid cycle into the current entry,
// feeds that entry back as the next partial sum, and after the programmed
// number of passes drains the tile row by row with saturation to OUT_W.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a tile (IDLE only); num_passes sampled here, 0 -> 1
//   psum_valid  : psum_in valid for entry_idx
//   psum_in     : MAC results, lane i at [i*PSUM_W +: PSUM_W]
//   psum_fb     : feedback partial sums for entry_idx (zero on first pass)
//   entry_idx   : current accumulate entry
//   busy        : high in ACCUM or DRAIN
//   tile_done   : one-cycle pulse after the last drained row
//   drain       : valid/ready row output bus
module psum_accum_buffer
  import mac_pkg::*;
#(
  parameter int unsigned OUT_W = PSUM_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              num_passes,
  input  logic                    psum_valid,
  input  logic [LANES*PSUM_W-1:0] psum_in,
  output logic [LANES*PSUM_W-1:0] psum_fb,
  output logic [IDX_W-1:0]        entry_idx,
  output logic                    busy,
  output logic                    tile_done,
  psum_accum_buffer_if.master     drain
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DEPTH - 1);

  state_e                  state_q;
  logic [7:0]              passes_q;
  logic [7:0]              pass_cnt_q;
  logic [IDX_W-1:0]        entry_idx_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic                    busy_q;
  logic                    out_valid_q;
  logic                    tile_done_q;

  logic [LANES*PSUM_W-1:0] mem_q [DEPTH];
  logic [LANES*PSUM_W-1:0] drain_row;
  logic [LANES*OUT_W-1:0]  out_data;

  logic wr_en;
  logic last_entry;
  logic last_pass;

  assign wr_en      = (state_q == ACCUM) && psum_valid;
  assign last_entry = (entry_idx_q == LastIdx);
  assign last_pass  = (pass_cnt_q == passes_q - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      passes_q    <= 8'd1;
      pass_cnt_q  <= '0;
      entry_idx_q <= '0;
      out_idx_q   <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      tile_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= ACCUM;
            busy_q      <= 1'b1;
            passes_q    <= (num_passes == 8'd0) ? 8'd1 : num_passes;
            pass_cnt_q  <= '0;
            entry_idx_q <= '0;
          end
        end
        ACCUM: begin
          if (psum_valid) begin
            entry_idx_q <= entry_idx_q + 1'b1;
            if (last_entry) begin
              if (last_pass) begin
                state_q     <= DRAIN;
                out_valid_q <= 1'b1;
                out_idx_q   <= '0;
              end else begin
                pass_cnt_q <= pass_cnt_q + 8'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (drain.out_ready) begin
            out_idx_q <= out_idx_q + 1'b1;
            if (out_idx_q == LastIdx) begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              tile_done_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; the first pass never reads it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[entry_idx_q] <= psum_in;
    end
  end

  always_comb begin
    psum_fb = '0;
    if ((state_q == ACCUM) && (pass_cnt_q != 8'd0)) begin
      psum_fb = mem_q[entry_idx_q];
    end
  end

  assign drain_row = mem_q[out_idx_q];

  for (genvar i = 0; i < LANES; i++) begin : g_lane_sat
    psum_sat #(
      .IN_W  (PSUM_W),
      .OUT_W (OUT_W)
    ) u_sat (
      .din  (drain_row[i*PSUM_W +: PSUM_W]),
      .dout (out_data[i*OUT_W +: OUT_W])
    );
  end

  assign drain.out_valid = out_valid_q;
  assign drain.out_data  = out_data;
  assign drain.out_idx   = out_idx_q;
  assign entry_idx       = entry_idx_q;
  assign busy            = busy_q;
  assign tile_done       = tile_done_q;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Directed bench for psum_accum_buffer: a full-width instance and a 16-bit
// saturating instance share all stimulus.
module tb_psum_accum_buffer;
  import mac_pkg::*;

  localparam int RW = LANES * PSUM_W;
  localparam int SW = LANES * 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      num_passes = 8'd0;
  logic            psum_valid = 1'b0;
  logic [RW-1:0]   psum_in = '0;
  logic            out_ready = 1'b0;

  logic [RW-1:0]    psum_fb, psum_fb_s;
  logic [IDX_W-1:0] entry_idx, entry_idx_s;
  logic             busy, busy_s, tile_done, tile_done_s;

  psum_accum_buffer_if #(.OUT_W(PSUM_W)) drain_if ();
  psum_accum_buffer_if #(.OUT_W(16))     drain_s_if ();

  assign drain_if.out_ready   = out_ready;
  assign drain_s_if.out_ready = out_ready;

  psum_accum_buffer #(.OUT_W(PSUM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_passes (num_passes),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .psum_fb    (psum_fb),
    .entry_idx  (entry_idx),
    .busy       (busy),
    .tile_done  (tile_done),
    .drain      (drain_if)
  );

  psum_accum_buffer #(.OUT_W(16)) dut_s (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_passes (num_passes),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .psum_fb    (psum_fb_s),
    .entry_idx  (entry_idx_s),
    .busy       (busy_s),
    .tile_done  (tile_done_s),
    .drain      (drain_s_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] din;
    logic [23:0] exp24;
    logic [15:0] exp16;
  } sat_vec_t;

  sat_vec_t      vecs [8];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [RW-1:0] exp_rows [DEPTH];
  logic [SW-1:0] exp_sat  [DEPTH];

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] fill(input int v);
    logic [RW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*PSUM_W +: PSUM_W] = PSUM_W'(v);
    return r;
  endfunction

  function automatic logic [RW-1:0] ramp(input int e, input int off);
    logic [RW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*PSUM_W +: PSUM_W] = PSUM_W'(e * 16 + i + off);
    return r;
  endfunction

  function automatic logic [15:0] sat16(input logic [23:0] x);
    int v;
    v = $signed(x);
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return x[15:0];
  endfunction

  task automatic set_exp_sat;
    for (int r = 0; r < DEPTH; r++)
      for (int i = 0; i < LANES; i++)
        exp_sat[r][i*16 +: 16] = sat16(exp_rows[r][i*PSUM_W +: PSUM_W]);
  endtask

  task automatic do_start(input logic [7:0] np);
    start = 1'b1;
    num_passes = np;
    tick;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_idx", entry_idx, 0);
  endtask

  // Drains one tile; bp selects the 1,0,0,1 ready pattern. start and
  // psum_valid are held high (ignored) until the final row's cycle.
  task automatic drain(input bit bp, input bit restart, input logic [7:0] np);
    int count = 0;
    int cyc = 0;
    bit rdy;
    while (count < DEPTH && cyc < 200) begin
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready  = rdy;
      start      = (count < DEPTH - 1);
      num_passes = 8'd9;
      psum_valid = 1'b1;
      psum_in    = fill(cyc + 77);
      check("drain_valid", drain_if.out_valid, 1);
      check("drain_idx", drain_if.out_idx, count);
      check("drain_data", drain_if.out_data, exp_rows[count]);
      check("drain_sat", drain_s_if.out_data, exp_sat[count]);
      check("drain_fb", psum_fb, 0);
      tick;
      if (rdy) count++;
      cyc++;
    end
    start = 1'b0;
    psum_valid = 1'b0;
    out_ready = 1'b0;
    check("drain_rows", count, DEPTH);
    check("done_pulse", tile_done, 1);
    check("done_busy", busy, 0);
    check("done_valid", drain_if.out_valid, 0);
    if (restart) begin
      start = 1'b1;
      num_passes = np;
      tick;
      start = 1'b0;
      check("restart_busy", busy, 1);
      check("restart_idx", entry_idx, 0);
      check("done_once", tile_done, 0);
    end else begin
      tick;
      check("done_once", tile_done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [RW-1:0] nxt;
    logic [RW-1:0] row;

    vecs[0] = '{24'h7fffff, 24'h7fffff, 16'h7fff};
    vecs[1] = '{24'h800000, 24'h800000, 16'h8000};
    vecs[2] = '{24'h000123, 24'h000123, 16'h0123};
    vecs[3] = '{24'hffffff, 24'hffffff, 16'hffff};
    vecs[4] = '{24'h008000, 24'h008000, 16'h7fff};
    vecs[5] = '{24'hff7fff, 24'hff7fff, 16'h8000};
    vecs[6] = '{24'hff8000, 24'hff8000, 16'h8000};
    vecs[7] = '{24'h007fff, 24'h007fff, 16'h7fff};

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_valid", drain_if.out_valid, 0);
    check("rst_done", tile_done, 0);
    check("rst_entry", entry_idx, 0);
    check("rst_out_idx", drain_if.out_idx, 0);
    rst_n = 1'b1;
    tick;

    // Single pass, feedback must stay zero
    do_start(8'd1);
    for (int e = 0; e < DEPTH; e++) begin
      check("t1_fb", psum_fb, 0);
      check("t1_idx", entry_idx, e);
      exp_rows[e] = ramp(e, 0);
      psum_valid = 1'b1;
      psum_in = exp_rows[e];
      tick;
    end
    psum_valid = 1'b0;
    set_exp_sat();
    drain(1'b0, 1'b0, 8'd0);

    // Three passes adding feedback+1, with a 5-cycle stall and ignored start
    do_start(8'd3);
    for (int p = 0; p < 3; p++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (p == 1 && e == 5) begin
          for (int s = 0; s < 5; s++) begin
            psum_valid = 1'b0;
            start = 1'b1;
            num_passes = 8'd7;
            tick;
            check("stall_idx", entry_idx, 5);
            check("stall_fb", psum_fb, fill(1));
            check("stall_busy", busy, 1);
          end
          start = 1'b0;
        end
        check("t2_fb", psum_fb, fill(p));
        check("t2_idx", entry_idx, e);
        for (int i = 0; i < LANES; i++)
          nxt[i*PSUM_W +: PSUM_W] = psum_fb[i*PSUM_W +: PSUM_W] + 24'd1;
        psum_valid = 1'b1;
        psum_in = nxt;
        tick;
      end
    end
    psum_valid = 1'b0;
    for (int e = 0; e < DEPTH; e++) exp_rows[e] = fill(3);
    set_exp_sat();
    drain(1'b1, 1'b0, 8'd0);

    // Saturation table, num_passes=0 acting as one pass; restart on tile_done
    do_start(8'd0);
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < LANES; k++) begin
        if (k < 8) row[k*PSUM_W +: PSUM_W] = vecs[k].din;
        else row[k*PSUM_W +: PSUM_W] = PSUM_W'(e * 3 - 20);
      end
      psum_valid = 1'b1;
      psum_in = row;
      for (int k = 0; k < 8; k++) row[k*PSUM_W +: PSUM_W] = vecs[k].exp24;
      exp_rows[e] = row;
      tick;
    end
    psum_valid = 1'b0;
    set_exp_sat();
    for (int e = 0; e < DEPTH; e++)
      for (int k = 0; k < 8; k++) exp_sat[e][k*16 +: 16] = vecs[k].exp16;
    drain(1'b0, 1'b1, 8'd2);

    // Two-pass tile aborted by reset at entry 7 of pass 1
    for (int e = 0; e < DEPTH; e++) begin
      psum_valid = 1'b1;
      psum_in = fill(1000);
      tick;
    end
    for (int e = 0; e < 7; e++) begin
      check("t4_fb", psum_fb, fill(1000));
      psum_valid = 1'b1;
      psum_in = fill(5);
      tick;
    end
    psum_valid = 1'b0;
    check("t4_idx", entry_idx, 7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_idx", entry_idx, 0);
    check("arst_valid", drain_if.out_valid, 0);
    check("arst_done", tile_done, 0);
    tick;
    check("arst_hold", busy, 0);
    rst_n = 1'b1;
    tick;
    check("post_rst_idle", busy, 0);
    check("post_rst_done", tile_done, 0);
    do_start(8'd1);
    for (int e = 0; e < DEPTH; e++) begin
      check("t4_fresh_fb", psum_fb, 0);
      exp_rows[e] = ramp(e, 5);
      psum_valid = 1'b1;
      psum_in = exp_rows[e];
      tick;
    end
    psum_valid = 1'b0;
    set_exp_sat();
    drain(1'b0, 1'b0, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
